// File: rtl/touch_coord_filter.sv
// Touch-panel front end: pen-down debounce, power-of-two X/Y averaging and jitter suppression.
// Optional `TOUCH_OUTLIER_REJECT_EN discards samples that sit on either ADC rail.
module touch_coord_filter #(
  parameter int AVG_LOG2     = 2,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int JITTER       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iPenIrq_n,
  input  logic        iADC_valid,
  input  logic [11:0] iADC_x,
  input  logic [11:0] iADC_y,
  output logic [11:0] x_coord,
  output logic [11:0] y_coord,
  output logic        new_coord,
  output logic        oTouching
);

  localparam int SW = 12 + AVG_LOG2;
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic [NW-1:0] WIN_LAST = NW'((1 << AVG_LOG2) - 1);
  localparam logic [CW:0]   DB_LAST  = (CW + 1)'(DEBOUNCE_CYC - 1);
  localparam logic [12:0]   JIT_LIM  = 13'(JITTER);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_PRESS_DB   = 2'd1;
  localparam logic [1:0] S_ACCUM      = 2'd2;
  localparam logic [1:0] S_RELEASE_DB = 2'd3;

  logic [1:0]    r_sync;
  logic [1:0]    r_state;
  logic [CW-1:0] r_db_cnt;
  logic [SW-1:0] r_sum_x;
  logic [SW-1:0] r_sum_y;
  logic [NW-1:0] r_n;
  logic          r_first;

  logic          w_pen;
  logic          w_sample_ok;
  logic [CW:0]   w_db_inc;
  logic          w_db_done;
  logic [SW-1:0] w_sum_x;
  logic [SW-1:0] w_sum_y;
  logic [11:0]   w_avg_x;
  logic [11:0]   w_avg_y;
  logic [12:0]   w_dx;
  logic [12:0]   w_dy;
  logic [12:0]   w_adx;
  logic [12:0]   w_ady;
  logic          w_last;
  logic          w_report;

  assign w_pen = ~r_sync[1];

`ifdef TOUCH_OUTLIER_REJECT_EN
  assign w_sample_ok = iADC_valid &&
                       (iADC_x != 12'h000) && (iADC_x != 12'hFFF) &&
                       (iADC_y != 12'h000) && (iADC_y != 12'hFFF);
`else
  assign w_sample_ok = iADC_valid;
`endif

  // Debounce is confirmed on the edge where the incremented count reaches the limit
  assign w_db_inc  = {1'b0, r_db_cnt} + 1'b1;
  assign w_db_done = (w_db_inc >= DB_LAST);

  assign w_sum_x = r_sum_x + SW'(iADC_x);
  assign w_sum_y = r_sum_y + SW'(iADC_y);
  assign w_avg_x = w_sum_x[AVG_LOG2 +: 12];
  assign w_avg_y = w_sum_y[AVG_LOG2 +: 12];
  assign w_last  = (r_n == WIN_LAST);

  assign w_dx     = {1'b0, w_avg_x} - {1'b0, x_coord};
  assign w_dy     = {1'b0, w_avg_y} - {1'b0, y_coord};
  assign w_adx    = w_dx[12] ? (13'd0 - w_dx) : w_dx;
  assign w_ady    = w_dy[12] ? (13'd0 - w_dy) : w_dy;
  assign w_report = r_first || (w_adx > JIT_LIM) || (w_ady > JIT_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], iPenIrq_n};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_db_cnt  <= '0;
      r_sum_x   <= '0;
      r_sum_y   <= '0;
      r_n       <= '0;
      r_first   <= 1'b0;
      x_coord   <= 12'd0;
      y_coord   <= 12'd0;
      new_coord <= 1'b0;
      oTouching <= 1'b0;
    end else begin
      new_coord <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_db_cnt <= '0;
          if (w_pen) begin
            r_state <= S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (!w_pen) begin
            r_state  <= S_IDLE;
            r_db_cnt <= '0;
          end else if (w_db_done) begin
            r_state   <= S_ACCUM;
            r_db_cnt  <= '0;
            oTouching <= 1'b1;
            r_first   <= 1'b1;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_n       <= '0;
          end else begin
            r_db_cnt <= w_db_inc[CW-1:0];
          end
        end
        S_ACCUM: begin
          // A sample arriving on the pen-lift edge is dropped along with the partial window
          if (!w_pen) begin
            r_state  <= S_RELEASE_DB;
            r_db_cnt <= '0;
          end else if (w_sample_ok) begin
            if (w_last) begin
              r_sum_x <= '0;
              r_sum_y <= '0;
              r_n     <= '0;
              if (w_report) begin
                x_coord   <= w_avg_x;
                y_coord   <= w_avg_y;
                new_coord <= 1'b1;
                r_first   <= 1'b0;
              end
            end else begin
              r_sum_x <= w_sum_x;
              r_sum_y <= w_sum_y;
              r_n     <= r_n + 1'b1;
            end
          end
        end
        S_RELEASE_DB: begin
          if (w_pen) begin
            r_state  <= S_ACCUM;
            r_db_cnt <= '0;
            r_sum_x  <= '0;
            r_sum_y  <= '0;
            r_n      <= '0;
          end else if (w_db_done) begin
            r_state   <= S_IDLE;
            r_db_cnt  <= '0;
            oTouching <= 1'b0;
          end else begin
            r_db_cnt <= w_db_inc[CW-1:0];
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_coord_filter.sv
// Directed bench for touch_coord_filter with a scoreboard of expected coordinate reports.
module tb_touch_coord_filter;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } coord_t;

  logic        clock;
  logic        reset;
  logic        iPenIrq_n;
  logic        iADC_valid;
  logic [11:0] iADC_x;
  logic [11:0] iADC_y;
  logic [11:0] x_coord;
  logic [11:0] y_coord;
  logic        new_coord;
  logic        oTouching;

  int     checks = 0;
  int     errors = 0;
  coord_t expQ[$];

  touch_coord_filter #(
    .AVG_LOG2    (2),
    .DEBOUNCE_CYC(4),
    .JITTER      (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iPenIrq_n (iPenIrq_n),
    .iADC_valid(iADC_valid),
    .iADC_x    (iADC_x),
    .iADC_y    (iADC_y),
    .x_coord   (x_coord),
    .y_coord   (y_coord),
    .new_coord (new_coord),
    .oTouching (oTouching)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One ADC sample; a report, when expected, must appear on the capturing edge
  task automatic applyStimulus(input logic [11:0] sx, input logic [11:0] sy,
                               input bit expReport, input logic [11:0] ex, input logic [11:0] ey);
    @(negedge clock);
    iADC_x     = sx;
    iADC_y     = sy;
    iADC_valid = 1'b1;
    if (expReport) expQ.push_back('{x: ex, y: ey});
    @(posedge clock);
    #1;
    iADC_valid = 1'b0;
    checkOutput("new_coord_on_sample", {31'd0, new_coord}, {31'd0, expReport});
  endtask

  task automatic waitTouch(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (oTouching === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard: every new_coord pulse consumes one expected coordinate
  always @(posedge clock) begin
    coord_t e;
    #1;
    if (new_coord === 1'b1) begin
      checkOutput("report_expected", {31'd0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("report_x", {20'd0, x_coord}, {20'd0, e.x});
        checkOutput("report_y", {20'd0, y_coord}, {20'd0, e.y});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    bit  sawTouch;

    reset      = 1'b0;
    iPenIrq_n  = 1'b1;
    iADC_valid = 1'b0;
    iADC_x     = 12'd0;
    iADC_y     = 12'd0;

    #2;
    checkOutput("reset_x", {20'd0, x_coord}, 32'd0);
    checkOutput("reset_y", {20'd0, y_coord}, 32'd0);
    checkOutput("reset_new", {31'd0, new_coord}, 32'd0);
    checkOutput("reset_touch", {31'd0, oTouching}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Short glitch must not confirm a press
    @(negedge clock);
    iPenIrq_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    iPenIrq_n = 1'b1;
    sawTouch = 1'b0;
    repeat (10) begin
      @(posedge clock);
      #1;
      sawTouch |= (oTouching === 1'b1);
    end
    checkOutput("glitch_no_touch", {31'd0, sawTouch}, 32'd0);

    @(negedge clock);
    iPenIrq_n = 1'b0;
    waitTouch(n);
    checkOutput("press_latency", n, 32'd6);

    applyStimulus(12'd100, 12'd200, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd102, 12'd200, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd104, 12'd200, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd106, 12'd200, 1'b1, 12'd103, 12'd200);
    @(posedge clock);
    #1;
    checkOutput("new_coord_one_cycle", {31'd0, new_coord}, 32'd0);

    // Average 110/205 is within jitter of 103/200
    applyStimulus(12'd108, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd110, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd110, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd112, 12'd205, 1'b0, 12'd0, 12'd0);
    checkOutput("jitter_hold_x", {20'd0, x_coord}, 32'd103);

    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd120, 12'd205, 1'b1, 12'd120, 12'd205);

    // Partial window then a brief lift: the partial samples must be thrown away
    applyStimulus(12'd4000, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd4000, 12'd205, 1'b0, 12'd0, 12'd0);
    @(negedge clock);
    iPenIrq_n = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    iPenIrq_n = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("bounce_keeps_touch", {31'd0, oTouching}, 32'd1);
    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd120, 12'd205, 1'b0, 12'd0, 12'd0);

    @(negedge clock);
    iPenIrq_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    checkOutput("release_touch", {31'd0, oTouching}, 32'd0);
    checkOutput("release_hold_x", {20'd0, x_coord}, 32'd120);
    checkOutput("release_hold_y", {20'd0, y_coord}, 32'd205);

    // Reset in the middle of a window
    @(negedge clock);
    iPenIrq_n = 1'b0;
    waitTouch(n);
    checkOutput("repress_latency", n, 32'd6);
    applyStimulus(12'd500, 12'd500, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd500, 12'd500, 1'b0, 12'd0, 12'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_x", {20'd0, x_coord}, 32'd0);
    checkOutput("midreset_y", {20'd0, y_coord}, 32'd0);
    checkOutput("midreset_new", {31'd0, new_coord}, 32'd0);
    checkOutput("midreset_touch", {31'd0, oTouching}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    waitTouch(n);
    checkOutput("post_reset_debounce", n, 32'd6);

    // Rail reading at the start of the window
`ifdef TOUCH_OUTLIER_REJECT_EN
    applyStimulus(12'hFFF, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b1, 12'd50, 12'd300);
    checkOutput("outlier_x", {20'd0, x_coord}, 32'd50);
`else
    applyStimulus(12'hFFF, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b0, 12'd0, 12'd0);
    applyStimulus(12'd50, 12'd300, 1'b1, 12'd1061, 12'd300);
    applyStimulus(12'd50, 12'd300, 1'b0, 12'd0, 12'd0);
    checkOutput("outlier_x", {20'd0, x_coord}, 32'd1061);
`endif

    repeat (3) @(posedge clock);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_coord_filter.md
# touch_coord_filter

Front-end conditioning stage between the touch-panel ADC interface and `touch_detector`. Qualifies pen-down with a debounce, averages raw 12-bit ADC X/Y samples over a power-of-two window, suppresses jitter while the pen is held, and emits stable `x_coord`/`y_coord` with a one-cycle `new_coord` strobe. Downstream logic sees one clean coordinate per real movement, not a stream of noisy samples.

## Interface
- `AVG_LOG2`, 2, log2 of samples averaged per report (window = 2^AVG_LOG2, range 0..4)
- `DEBOUNCE_CYC`, 500000, clocks the pen level must stay stable to confirm press or release (10 ms at 50 MHz)
- `JITTER`, 16, min per-axis change, in raw ADC units, to report a new coordinate while held
- `clock` in 1: single system clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `iPenIrq_n` in 1: raw pen-down from panel, active-low, asynchronous to `clock`
- `iADC_valid` in 1: one-cycle strobe, `iADC_x`/`iADC_y` valid
- `iADC_x` in 12: raw X sample, 0..4095
- `iADC_y` in 12: raw Y sample, 0..4095
- `x_coord` out 12: filtered X, held between reports
- `y_coord` out 12: filtered Y, held between reports
- `new_coord` out 1: one-cycle pulse, coordinate updated
- `oTouching` out 1: high while a press is confirmed

## Operation
- `iPenIrq_n` passes a 2-FF synchronizer; `pen` = synchronized inverse. All FSM decisions use `pen`.
- States: IDLE, PRESS_DB, ACCUM, RELEASE_DB.
- IDLE: debounce counter 0. `pen`=1 -> PRESS_DB.
- PRESS_DB: counter increments while `pen`=1; `pen`=0 -> IDLE. Counter reaching DEBOUNCE_CYC-1 -> ACCUM, `oTouching`<=1, accumulators cleared, `first`<=1. ADC samples ignored.
- ACCUM: each `iADC_valid` adds X/Y to sums (12+AVG_LOG2 bits, no overflow possible) and increments sample count. On the sample completing the window: avg = sum >> AVG_LOG2, truncating. Report when `first`=1, or |avgX−x_coord| > JITTER, or |avgY−y_coord| > JITTER (13-bit signed diff). Report updates both `x_coord` and `y_coord` and pulses `new_coord`; `first`<=0. Sums and count always clear at window end, reported or not. `pen`=0 -> RELEASE_DB, partial window discarded.
- RELEASE_DB: samples ignored. `pen`=1 before counter reaches DEBOUNCE_CYC-1 -> ACCUM, `first` unchanged, accumulators cleared. Counter reaches DEBOUNCE_CYC-1 -> IDLE, `oTouching`<=0. Outputs hold last coordinate.
- `iADC_valid` in the same cycle as a transition out of ACCUM is dropped.
- `iADC_valid` high in consecutive cycles: each cycle is one sample.

## Timing
- Reset (async assert): `x_coord`=0, `y_coord`=0, `new_coord`=0, `oTouching`=0, state IDLE, counters/sums 0, synchronizer=1 (pen up).
- Pen-input latency: 2 clocks (synchronizer) before the FSM sees a level change.
- Press confirm: `oTouching` rises DEBOUNCE_CYC+2 clocks after a stable `iPenIrq_n` fall.
- Report latency: `x_coord`/`y_coord` change and `new_coord` rises on the same edge that captures the window-completing `iADC_valid`. `new_coord` is high exactly one cycle.
- `new_coord` never fires in IDLE, PRESS_DB, or RELEASE_DB.
- Reset deassertion is synchronized externally; the block needs no internal release logic.

## Configuration
- `TOUCH_OUTLIER_REJECT_EN` defined: a valid sample with either axis equal to 12'h000 or 12'hFFF (panel rail/open reading) is discarded. It is not accumulated and not counted; the window waits for a good sample.
- Undefined: every valid sample is accumulated.

## Test plan
Bench params: AVG_LOG2=2, DEBOUNCE_CYC=4, JITTER=16.
- Pen low for 3 clocks, then high -> `oTouching` stays 0, no `new_coord`; pen low stable -> `oTouching`=1 at clock 6.
- Pressed, 4 samples X=100,102,104,106 / Y=200 each -> `new_coord` one cycle, `x_coord`=103, `y_coord`=200 on the 4th sample's edge.
- Next window averaging X=110, Y=205 -> no `new_coord`. Following window X=120 -> `new_coord`, `x_coord`=120, `y_coord`=205.
- 2 samples, then pen high 2 clocks and low again -> partial discarded, `first` kept; 4 fresh samples equal to held coord -> no `new_coord`; release 6+ clocks -> `oTouching`=0, coords held.
- With `TOUCH_OUTLIER_REJECT_EN`: samples X=0xFFF,50,50,50,50 -> `new_coord` after the 5th sample, `x_coord`=50. Without the macro -> report after the 4th sample, `x_coord`=(4095+150)>>2=1061.
- Reset asserted mid-window while `oTouching`=1 -> all outputs 0 immediately; after release, a new full press debounce is required.
